// File: rtl/bp_me_cache_port_arbiter_pkg.sv
// Shared cache packet types and widths for the cache port arbiter.
// Widths stand in for the bp_params_p configuration defaults.
package bp_me_cache_port_arbiter_pkg;

    localparam int caddr_width_gp   = 32;
    localparam int l2_data_width_gp = 64;
    localparam int opcode_width_gp  = 6;

    typedef enum logic [opcode_width_gp-1:0] {
        e_cache_lw    = 6'h02,
        e_cache_ld    = 6'h03,
        e_cache_tagst = 6'h08,
        e_cache_sw    = 6'h12,
        e_cache_sd    = 6'h13,
        e_cache_lm    = 6'h1a,
        e_cache_sm    = 6'h1b
    } bsg_cache_opcode_e;

    typedef struct packed {
        bsg_cache_opcode_e               opcode;
        logic [caddr_width_gp-1:0]       addr;
        logic [l2_data_width_gp-1:0]     data;
        logic [l2_data_width_gp/8-1:0]   mask;
    } bsg_cache_pkt_s;

    function automatic int cache_pkt_width(int caddr_w, int data_w);
        return opcode_width_gp + caddr_w + data_w + data_w / 8;
    endfunction

    function automatic int safe_clog2(int x);
        return (x > 1) ? $clog2(x) : 1;
    endfunction

    localparam int pkt_width_gp =
        cache_pkt_width(caddr_width_gp, l2_data_width_gp);

endpackage

// File: rtl/bp_me_cache_port_arbiter_fifo.sv
// Small 1-read/1-write FIFO holding requester IDs of in-flight packets.
// Full blocks enqueue regardless of a same-cycle dequeue.
module bp_me_cache_port_arbiter_fifo
    import bp_me_cache_port_arbiter_pkg::*;
#(
    parameter int width_p = 1,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = safe_clog2(els_p);
    localparam int cnt_w_lp = safe_clog2(els_p + 1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] rd_ptr_r;
    logic [ptr_w_lp-1:0] wr_ptr_r;
    logic [cnt_w_lp-1:0] count_r;
    logic                enq;
    logic                deq;

    assign ready_o = (count_r != cnt_w_lp'(els_p));
    assign v_o     = (count_r != '0);
    assign data_o  = mem_r[rd_ptr_r];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
            unique case ({enq, deq})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage write; contents need no reset since v_o gates reads.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/bp_me_cache_port_arbiter.sv
// Round-robin arbiter sharing one bsg_cache port among several requesters,
// with locked bursts and in-order response routing by tracked requester ID.
module bp_me_cache_port_arbiter
    import bp_me_cache_port_arbiter_pkg::*;
#(
    parameter int num_req_p         = 2,
    parameter int max_outstanding_p = 4,
    parameter int caddr_width_p     = caddr_width_gp,
    parameter int l2_data_width_p   = l2_data_width_gp,
    localparam int pkt_width_lp =
        cache_pkt_width(caddr_width_p, l2_data_width_p)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,

    input  logic [num_req_p*pkt_width_lp-1:0] req_pkt_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p-1:0]              req_lock_i,
    output logic [num_req_p-1:0]              req_ready_and_o,

    output logic [l2_data_width_p-1:0]        req_data_o,
    output logic [num_req_p-1:0]              req_v_o,
    input  logic [num_req_p-1:0]              req_yumi_i,

    output logic [pkt_width_lp-1:0]           cache_pkt_o,
    output logic                              cache_v_o,
    input  logic                              cache_ready_i,

    input  logic [l2_data_width_p-1:0]        cache_data_i,
    input  logic                              cache_v_i,
    output logic                              cache_yumi_o
);

    localparam int id_width_lp = safe_clog2(num_req_p);

    logic [id_width_lp-1:0] ptr_r;
    logic                   lock_r;
    logic [id_width_lp-1:0] owner_r;

    logic [num_req_p-1:0]   owner_mask;
    logic [num_req_p-1:0]   eligible;
    logic [id_width_lp-1:0] winner;
    logic                   winner_v;
    logic [id_width_lp-1:0] winner_next;

    logic                   fifo_ready;
    logic                   fifo_v;
    logic [id_width_lp-1:0] head_id;
    logic                   issue_ok;
    logic                   handshake;

    // A held lock narrows the eligible set to the owning requester.
    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_r] = 1'b1;
        eligible            = lock_r ? (req_v_i & owner_mask) : req_v_i;
    end

    // Round-robin search starting at the index after the last grant.
    always_comb begin
        logic [id_width_lp:0] idx;
        idx      = '0;
        winner   = '0;
        winner_v = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = {1'b0, ptr_r} + (id_width_lp+1)'(i);
            if (idx >= (id_width_lp+1)'(num_req_p))
                idx = idx - (id_width_lp+1)'(num_req_p);
            if (!winner_v && eligible[idx[id_width_lp-1:0]]) begin
                winner   = idx[id_width_lp-1:0];
                winner_v = 1'b1;
            end
        end
    end

    assign winner_next = (winner == id_width_lp'(num_req_p - 1))
                       ? '0 : winner + 1'b1;

    assign issue_ok  = cache_ready_i & fifo_ready & ~reset_i;
    assign handshake = winner_v & issue_ok;
    assign cache_v_o = winner_v;

    // Forward the winning packet; zero when nobody is eligible.
    always_comb begin
        cache_pkt_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (winner_v && winner == id_width_lp'(i))
                cache_pkt_o = req_pkt_i[i*pkt_width_lp +: pkt_width_lp];
        end
    end

    // Only the winner sees ready, and only when the port can take it.
    always_comb begin
        req_ready_and_o = '0;
        if (winner_v)
            req_ready_and_o[winner] = issue_ok;
    end

    // Pointer advances every packet; lock follows the winner's request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r   <= '0;
            lock_r  <= 1'b0;
            owner_r <= '0;
        end else if (handshake) begin
            ptr_r   <= winner_next;
            lock_r  <= req_lock_i[winner];
            owner_r <= winner;
        end
    end

    bp_me_cache_port_arbiter_fifo #(
        .width_p (id_width_lp),
        .els_p   (max_outstanding_p)
    ) id_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (handshake),
        .ready_o (fifo_ready),
        .data_i  (winner),
        .v_o     (fifo_v),
        .data_o  (head_id),
        .yumi_i  (cache_yumi_o)
    );

    assign req_data_o   = cache_data_i;
    assign cache_yumi_o = fifo_v & req_yumi_i[head_id];

    // Responses return in issue order to the requester at the FIFO head.
    always_comb begin
        req_v_o          = '0;
        req_v_o[head_id] = cache_v_i & fifo_v;
    end

`ifndef SYNTHESIS
    // Protocol checks on the cache and requester sides.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!cache_v_i || fifo_v)
                else $error("cache response with no tracked id");
            assert ((req_yumi_i & ~req_v_o) == '0)
                else $error("requester yumi without its response valid");
            assert (!(lock_r && req_lock_i[owner_r] && !req_v_i[owner_r]))
                else $error("lock asserted by owner without valid");
        end
    end
`endif

endmodule

// File: tb/tb_bp_me_cache_port_arbiter.sv
// Self-checking bench for the cache port arbiter.
// A queue-based model of grants and response routing predicts every output.
module tb_bp_me_cache_port_arbiter;
    import bp_me_cache_port_arbiter_pkg::*;

    localparam int NR    = 2;
    localparam int MAXO  = 4;
    localparam int PKT_W = pkt_width_gp;
    localparam int DW    = l2_data_width_gp;

    logic                clk = 1'b0;
    logic                reset_i;
    logic [NR*PKT_W-1:0] req_pkt_i;
    logic [NR-1:0]       req_v_i, req_lock_i, req_ready_and_o;
    logic [DW-1:0]       req_data_o;
    logic [NR-1:0]       req_v_o, req_yumi_i;
    logic [PKT_W-1:0]    cache_pkt_o;
    logic                cache_v_o, cache_ready_i;
    logic [DW-1:0]       cache_data_i;
    logic                cache_v_i, cache_yumi_o;

    bp_me_cache_port_arbiter #(
        .num_req_p(NR), .max_outstanding_p(MAXO)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_pkt_i(req_pkt_i), .req_v_i(req_v_i),
        .req_lock_i(req_lock_i), .req_ready_and_o(req_ready_and_o),
        .req_data_o(req_data_o), .req_v_o(req_v_o),
        .req_yumi_i(req_yumi_i),
        .cache_pkt_o(cache_pkt_o), .cache_v_o(cache_v_o),
        .cache_ready_i(cache_ready_i),
        .cache_data_i(cache_data_i), .cache_v_i(cache_v_i),
        .cache_yumi_o(cache_yumi_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0]    rdy;
        logic             cv;
        logic [PKT_W-1:0] pkt;
        logic [NR-1:0]    vo;
        logic [DW-1:0]    data;
        logic             yumi;
    } view_t;

    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    logic [NR-1:0]  s_v, s_lock, yumi_en;
    logic           s_ready, resp_en;
    bsg_cache_pkt_s s_pkt [NR];

    int            m_ptr, m_owner, m_win;
    bit            m_lock, m_issue;
    exp_t          m_q [$];
    logic [DW-1:0] h_q [$];
    view_t         exp_view, obs_view;
    int            checks = 0;
    int            errors = 0;

    function automatic logic [DW-1:0] echo(bsg_cache_pkt_s p);
        return DW'(p.addr);
    endfunction

    task automatic new_pkt(int i, bsg_cache_opcode_e op);
        s_pkt[i].opcode = op;
        s_pkt[i].addr   = $urandom;
        s_pkt[i].data   = {$urandom, $urandom};
        s_pkt[i].mask   = '1;
    endtask

    task automatic apply_reset(int n);
        reset_i = 1'b1;
        s_v = '0; s_lock = '0; s_ready = 1'b0;
        resp_en = 1'b0; yumi_en = '0;
        req_v_i = '0; req_lock_i = '0; req_yumi_i = '0;
        cache_v_i = 1'b0; cache_ready_i = 1'b0; cache_data_i = '0;
        repeat (n) @(posedge clk);
        #1 reset_i = 1'b0;
        m_q.delete(); h_q.delete();
        m_ptr = 0; m_lock = 1'b0; m_owner = 0;
    endtask

    // Drive one cycle of stimulus, settle, and predict outputs at negedge.
    task automatic run_cycle();
        logic [NR-1:0] elig;
        bit            ok;
        @(posedge clk); #1;
        for (int i = 0; i < NR; i++)
            req_pkt_i[i*PKT_W +: PKT_W] = s_pkt[i];
        req_v_i       = s_v;
        req_lock_i    = s_lock & s_v;
        cache_ready_i = s_ready;
        cache_v_i     = resp_en && (h_q.size() > 0);
        cache_data_i  = (h_q.size() > 0) ? h_q[0] : '0;
        #1 req_yumi_i = req_v_o & yumi_en;
        @(negedge clk);
        elig = m_lock ? (req_v_i & (NR'(1) << m_owner)) : req_v_i;
        m_win = -1;
        for (int k = 0; k < NR; k++) begin
            int idx;
            idx = (m_ptr + k) % NR;
            if (m_win < 0 && elig[idx]) m_win = idx;
        end
        ok = cache_ready_i && (m_q.size() < MAXO);
        m_issue = (m_win >= 0) && ok;
        exp_view.rdy = m_issue ? (NR'(1) << m_win) : '0;
        exp_view.cv  = (m_win >= 0);
        exp_view.pkt = (m_win >= 0) ? s_pkt[m_win] : '0;
        exp_view.vo  = (cache_v_i && m_q.size() > 0)
                     ? (NR'(1) << m_q[0].id) : '0;
        exp_view.data = (cache_v_i && m_q.size() > 0)
                      ? m_q[0].data : cache_data_i;
        exp_view.yumi = (m_q.size() > 0) && req_yumi_i[m_q[0].id];
        obs_view.rdy  = req_ready_and_o;
        obs_view.cv   = cache_v_o;
        obs_view.pkt  = cache_pkt_o;
        obs_view.vo   = req_v_o;
        obs_view.data = req_data_o;
        obs_view.yumi = cache_yumi_o;
    endtask

    // Advance model, cache harness and packet stimulus past the edge.
    task automatic commit();
        if (cache_yumi_o && h_q.size() > 0) void'(h_q.pop_front());
        if (cache_v_o && |req_ready_and_o)
            h_q.push_back(echo(bsg_cache_pkt_s'(cache_pkt_o)));
        if (exp_view.yumi) void'(m_q.pop_front());
        if (m_issue) begin
            m_q.push_back('{m_win, echo(s_pkt[m_win])});
            m_ptr   = (m_win + 1) % NR;
            m_lock  = req_lock_i[m_win];
            m_owner = m_win;
        end
        for (int i = 0; i < NR; i++)
            if (req_v_i[i] && req_ready_and_o[i])
                new_pkt(i, s_pkt[i].opcode);
    endtask

    task automatic test_reset();
        apply_reset(3);
        for (int c = 0; c < 3; c++) begin
            run_cycle();
            checks++;
            if ({req_ready_and_o, req_v_o, cache_v_o, cache_yumi_o} !== '0) begin
                errors++;
                $display("FAIL reset_idle c=%0d got rdy=%b vo=%b cv=%b yumi=%b want 0",
                         c, req_ready_and_o, req_v_o, cache_v_o, cache_yumi_o);
            end
            checks++;
            if (obs_view !== exp_view) begin
                errors++;
                $display("FAIL reset_view c=%0d got=%h want=%h", c, obs_view, exp_view);
            end
            commit();
        end
    endtask

    task automatic test_alternate();
        new_pkt(0, e_cache_lw); new_pkt(1, e_cache_lw);
        s_v = 2'b11; s_ready = 1'b1; resp_en = 1'b1; yumi_en = 2'b11;
        for (int c = 0; c < 12; c++) begin
            run_cycle();
            checks++;
            if (req_ready_and_o !== 2'(1 << (c % 2))) begin
                errors++;
                $display("FAIL alt_grant c=%0d got=%b want=%b",
                         c, req_ready_and_o, 2'(1 << (c % 2)));
            end
            checks++;
            if (obs_view !== exp_view) begin
                errors++;
                $display("FAIL alt_view c=%0d got=%h want=%h", c, obs_view, exp_view);
            end
            commit();
        end
    endtask

    task automatic test_lock();
        int beats = 0;
        logic [NR-1:0] want;
        apply_reset(2);
        new_pkt(0, e_cache_sm); new_pkt(1, e_cache_lw);
        s_ready = 1'b1; resp_en = 1'b1; yumi_en = 2'b11;
        for (int c = 0; c < 14; c++) begin
            s_v    = {1'b1, beats < 8};
            s_lock = {1'b0, beats < 7};
            run_cycle();
            if (c <= 8) begin
                want = (c < 8) ? 2'b01 : 2'b10;
                checks++;
                if (req_ready_and_o !== want) begin
                    errors++;
                    $display("FAIL lock_grant c=%0d got=%b want=%b",
                             c, req_ready_and_o, want);
                end
            end
            checks++;
            if (obs_view !== exp_view) begin
                errors++;
                $display("FAIL lock_view c=%0d got=%h want=%h", c, obs_view, exp_view);
            end
            if (req_ready_and_o[0] && req_v_i[0]) beats++;
            commit();
        end
    endtask

    task automatic test_full();
        int acc = 0;
        apply_reset(2);
        new_pkt(0, e_cache_lw);
        s_v = 2'b01; s_ready = 1'b1; resp_en = 1'b0; yumi_en = 2'b11;
        for (int c = 0; c < 8; c++) begin
            resp_en = (c == 6);
            run_cycle();
            checks++;
            if (req_ready_and_o !== ((c < 4 || c == 7) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL full_ready c=%0d got=%b", c, req_ready_and_o);
            end
            if (c == 6) begin
                checks++;
                if (cache_yumi_o !== 1'b1) begin
                    errors++;
                    $display("FAIL full_pop got=%b want=1", cache_yumi_o);
                end
            end
            checks++;
            if (obs_view !== exp_view) begin
                errors++;
                $display("FAIL full_view c=%0d got=%h want=%h", c, obs_view, exp_view);
            end
            if (req_ready_and_o[0] && c < 6) acc++;
            commit();
        end
        checks++;
        if (acc !== 4) begin
            errors++;
            $display("FAIL full_count got=%0d want=4", acc);
        end
        s_v = '0; resp_en = 1'b1;
        repeat (6) begin run_cycle(); commit(); end
    endtask

    task automatic test_yumi_stall();
        logic [NR-1:0] want_v;
        apply_reset(2);
        s_ready = 1'b1; yumi_en = 2'b11;
        s_v = 2'b10; run_cycle(); commit();
        s_v = 2'b01; run_cycle(); commit();
        s_v = 2'b00; resp_en = 1'b1;
        for (int c = 0; c < 6; c++) begin
            yumi_en = (c < 3) ? 2'b01 : 2'b11;
            run_cycle();
            want_v = (c < 4) ? 2'b10 : (c == 4) ? 2'b01 : 2'b00;
            checks++;
            if (req_v_o !== want_v
                || cache_yumi_o !== (c >= 3 && c <= 4)) begin
                errors++;
                $display("FAIL stall c=%0d got vo=%b yumi=%b want vo=%b",
                         c, req_v_o, cache_yumi_o, want_v);
            end
            checks++;
            if (obs_view !== exp_view) begin
                errors++;
                $display("FAIL stall_view c=%0d got=%h want=%h", c, obs_view, exp_view);
            end
            commit();
        end
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] want;
        apply_reset(2);
        s_ready = 1'b1;
        s_v = 2'b10; run_cycle(); commit();
        s_v = 2'b01; run_cycle(); commit();
        s_v = 2'b01; run_cycle(); commit();
        apply_reset(1);
        s_ready = 1'b1; s_v = 2'b11;
        for (int c = 0; c < 5; c++) begin
            run_cycle();
            want = (c == 4) ? 2'b00 : 2'(1 << (c % 2));
            checks++;
            if (req_ready_and_o !== want) begin
                errors++;
                $display("FAIL rst_ptr c=%0d got=%b want=%b", c, req_ready_and_o, want);
            end
            commit();
        end
        apply_reset(1);
        s_ready = 1'b1; resp_en = 1'b1; yumi_en = 2'b11;
        s_v = 2'b10; s_lock = 2'b10;
        repeat (3) begin run_cycle(); commit(); end
        apply_reset(1);
        s_ready = 1'b1; s_v = 2'b11;
        for (int c = 0; c < 2; c++) begin
            run_cycle();
            checks++;
            if (req_ready_and_o !== 2'(1 << c)) begin
                errors++;
                $display("FAIL rst_lock c=%0d got=%b want=%b",
                         c, req_ready_and_o, 2'(1 << c));
            end
            checks++;
            if (obs_view !== exp_view) begin
                errors++;
                $display("FAIL rst_view c=%0d got=%h want=%h", c, obs_view, exp_view);
            end
            commit();
        end
    endtask

    task automatic test_random();
        apply_reset(2);
        new_pkt(0, e_cache_sw); new_pkt(1, e_cache_lw);
        for (int c = 0; c < 400; c++) begin
            s_v     = NR'($urandom);
            s_lock  = ($urandom_range(0, 7) == 0) ? NR'($urandom) : '0;
            s_ready = ($urandom_range(0, 3) != 0);
            resp_en = ($urandom_range(0, 3) != 0);
            yumi_en = NR'($urandom);
            run_cycle();
            checks++;
            if (obs_view !== exp_view) begin
                errors++;
                $display("FAIL rand_view c=%0d got=%h want=%h", c, obs_view, exp_view);
            end
            commit();
        end
    endtask

    initial begin
        reset_i = 1'b1;
        req_pkt_i = '0;
        new_pkt(0, e_cache_lw); new_pkt(1, e_cache_lw);
        test_reset();
        test_alternate();
        test_lock();
        test_full();
        test_yumi_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
